// File: rtl/issue_scoreboard.sv
// In-order N-lane issue scoreboard: per-register countdown, RAW/WAW gating.
// Optional EX/MEM forwarding variant selected by defining SB_FWD_EN.
module issue_scoreboard #(
    parameter int LANES  = 2,
    parameter int NREGS  = 32,
    parameter int WB_LAT = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LANES-1:0]   issue_valid,
    input  logic [LANES*5-1:0] issue_rs,
    input  logic [LANES*5-1:0] issue_rt,
    input  logic [LANES-1:0]   issue_rs_used,
    input  logic [LANES-1:0]   issue_rt_used,
    input  logic [LANES-1:0]   issue_wr_en,
    input  logic [LANES*5-1:0] issue_wr_reg,
    input  logic [LANES-1:0]   issue_is_load,
    input  logic               flush,
    output logic [LANES-1:0]   issue_grant,
    output logic [NREGS-1:0]   busy_mask,
    output logic [15:0]        stall_count
);

    localparam int CW = $clog2(WB_LAT + 1);

    logic [CW-1:0]    r_cnt [NREGS];
    logic [NREGS-1:0] r_ld;
    logic [15:0]      r_stall;
    logic [NREGS-1:0] w_blk;
    logic [4:0]       w_rs;
    logic [4:0]       w_rt;
    logic [4:0]       w_wd;
    logic [4:0]       w_wj;
    logic             w_haz;
    logic             w_ok;

    assign stall_count = r_stall;

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            busy_mask[r] = (r_cnt[r] != '0);
`ifdef SB_FWD_EN
            // only a load still in EX cannot be forwarded
            w_blk[r] = (r_cnt[r] == CW'(WB_LAT)) && r_ld[r];
`else
            w_blk[r] = (r_cnt[r] != '0);
`endif
        end
        busy_mask[0] = 1'b0;
        w_blk[0]     = 1'b0;
    end

    always_comb begin
        w_ok        = !flush && !rst;
        issue_grant = '0;
        w_rs        = '0;
        w_rt        = '0;
        w_wd        = '0;
        w_wj        = '0;
        w_haz       = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            w_rs  = issue_rs[5*i +: 5];
            w_rt  = issue_rt[5*i +: 5];
            w_wd  = issue_wr_reg[5*i +: 5];
            w_haz = (issue_rs_used[i] && w_blk[w_rs])
                 || (issue_rt_used[i] && w_blk[w_rt]);
            for (int j = 0; j < LANES; j++) begin
                w_wj = issue_wr_reg[5*j +: 5];
                if (j < i && issue_wr_en[j] && w_wj != '0) begin
                    if (issue_rs_used[i] && w_rs == w_wj)
                        w_haz = 1'b1;
                    if (issue_rt_used[i] && w_rt == w_wj)
                        w_haz = 1'b1;
                    if (issue_wr_en[i] && w_wd == w_wj)
                        w_haz = 1'b1;
                end
            end
            w_ok           = w_ok && issue_valid[i] && !w_haz;
            issue_grant[i] = w_ok;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++)
                r_cnt[r] <= '0;
            r_ld    <= '0;
            r_stall <= '0;
        end else begin
            if (issue_valid[0] && !issue_grant[0] && !flush
                && r_stall != 16'hFFFF)
                r_stall <= r_stall + 16'd1;
            if (flush) begin
                for (int r = 0; r < NREGS; r++)
                    r_cnt[r] <= '0;
                r_ld <= '0;
            end else begin
                for (int r = 0; r < NREGS; r++) begin
                    if (r_cnt[r] != '0) begin
                        r_cnt[r] <= r_cnt[r] - CW'(1);
                        if (r_cnt[r] == CW'(1))
                            r_ld[r] <= 1'b0;
                    end
                end
                // a fresh producer overrides the decrement
                for (int i = 0; i < LANES; i++) begin
                    if (issue_grant[i] && issue_wr_en[i]
                        && issue_wr_reg[5*i +: 5] != '0) begin
                        r_cnt[issue_wr_reg[5*i +: 5]] <= CW'(WB_LAT);
                        r_ld[issue_wr_reg[5*i +: 5]]  <= issue_is_load[i];
                    end
                end
            end
        end
    end

endmodule
